log2_iter: RTL and testbench

Sequential IEEE-754 single-precision base-2 logarithm unit, the first stage of the x^y datapath. It produces log2(x), which the following multiplier scales by y. The unit uses exponent extraction plus bit-serial mantissa squaring, one result bit per cycle. Operands and results use valid/ready handshakes, so the stage can be stalled by the downstream pipeline.

---
 rtl/xpowy_pkg.sv | 30 +++
 rtl/log2_iter_if.sv | 14 +
 rtl/fp32_norm_pack.sv | 33 +++
 rtl/log2_iter.sv | 100 ++++++++++
 tb/tb_log2_iter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/xpowy_pkg.sv
// Shared fp32 definitions for the x^y datapath stages: field widths,
// special-value constants, FSM state encoding and operand classification.
package xpowy_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;

  // Operands whose log2 is a constant: zero/denormal, negative, inf, NaN.
  function automatic logic fp32_is_special(input logic [31:0] x);
    return (x[30:23] == '0) || x[31] || (x[30:23] == '1);
  endfunction

  function automatic logic [31:0] fp32_special_result(input logic [31:0] x);
    logic [31:0] r;
    if (x[30:23] == '0)      r = FP32_NEG_INF;
    else if (x[31])          r = FP32_QNAN;
    else if (x[22:0] == '0)  r = FP32_POS_INF;
    else                     r = FP32_QNAN;
    return r;
  endfunction

endpackage

// File: rtl/log2_iter_if.sv
// Operand/result valid-ready handshake bundle for the log2 stage.
interface log2_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/fp32_norm_pack.sv
// Packs a signed fixed-point value (9 integer + FRAC_BITS fraction bits)
// into fp32 with truncation toward zero.
module fp32_norm_pack
  import xpowy_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 28
) (
  input  logic signed [FRAC_BITS+8:0] i_v,
  output logic [31:0]                 o_fp
);

  localparam int unsigned W = FRAC_BITS + 9;

  logic             w_sign;
  logic [W-1:0]     w_mag;
  logic [5:0]       w_pos;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  always_comb begin
    w_sign = i_v[W-1];
    w_mag  = w_sign ? W'(-i_v) : W'(i_v);
    w_pos  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (w_mag[i]) w_pos = 6'(i);
    end
    w_exp = EXP_W'(32'(w_pos) + BIAS - FRAC_BITS);
    // Align leading one to the MSB, then take the 23 bits beneath it.
    w_man = MAN_W'((w_mag << (W - 1 - 32'(w_pos))) >> (W - 24));
    o_fp  = (i_v == '0) ? FP32_ZERO : {w_sign, w_exp, w_man};
  end

endmodule

// File: rtl/log2_iter.sv
// Sequential fp32 log2: exponent extraction plus bit-serial mantissa
// squaring, one fraction bit per ITER cycle, valid/ready on both sides.
module log2_iter
  import xpowy_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 28
) (
  input logic       clk,
  input logic       rst,
  log2_iter_if.slave bus
);

  localparam int unsigned VW = FRAC_BITS + 9;

  state_t                r_state;
  logic [23:0]           r_m;
  logic [8:0]            r_e;
  logic [FRAC_BITS-1:0]  r_f;
  logic [5:0]            r_n;
  logic [31:0]           r_out_data;
  logic                  r_out_valid;
  logic                  r_in_ready;

  logic [47:0]           w_p;
  logic [23:0]           w_m_next;
  logic signed [VW-1:0]  w_v;
  logic [31:0]           w_packed;
  logic [EXP_W-1:0]      w_in_exp;
  logic [MAN_W-1:0]      w_in_man;

  assign w_in_exp = bus.in_data[30:23];
  assign w_in_man = bus.in_data[22:0];

  // m in [1,2) squared lands in [1,4); renormalise by one bit when >= 2.
  assign w_p      = {24'b0, r_m} * {24'b0, r_m};
  assign w_m_next = 24'(w_p >> (w_p[47] ? 24 : 23));
  assign w_v      = {r_e, r_f};

  fp32_norm_pack #(.FRAC_BITS(FRAC_BITS)) u_pack (
    .i_v  (w_v),
    .o_fp (w_packed)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_e         <= '0;
      r_f         <= '0;
      r_n         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (fp32_is_special(bus.in_data)) begin
              r_out_data <= fp32_special_result(bus.in_data);
              r_state    <= DONE;
            end else begin
              r_e     <= {1'b0, w_in_exp} - 9'(BIAS);
              r_m     <= {1'b1, w_in_man};
              r_f     <= '0;
              r_n     <= '0;
              r_state <= ITER;
            end
          end
        end
        ITER: begin
          r_f <= {r_f[FRAC_BITS-2:0], w_p[47]};
          r_m <= w_m_next;
          r_n <= r_n + 6'd1;
          if (r_n == 6'(FRAC_BITS - 1)) r_state <= NORM;
        end
        NORM: begin
          r_out_data <= w_packed;
          r_state    <= DONE;
        end
        DONE: begin
          // First DONE cycle raises out_valid; the handshake is taken after.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_iter.sv
// Self-checking bench for log2_iter: directed vector table, multi-cycle
// corner sequences and a random sweep against a real-valued log2 model.
module tb_log2_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  log2_iter_if bus();

  log2_iter #(.FRAC_BITS(28)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] want;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_to_real(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -v : v;
  endfunction

  function automatic real ref_log2(input logic [31:0] x);
    return real'(int'(x[30:23]) - 127) + $ln(1.0 + real'(x[22:0]) / 8388608.0) / $ln(2.0);
  endfunction

  // Present one operand, return result and cycles from accept edge to out_valid.
  task automatic do_op(input logic [31:0] x, output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    res = bus.out_data;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout x=%h: got no out_valid want one within 200 cycles", x);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] res;
    int          lat;
    int          seen;
    int          diff;

    vecs[0]  = '{x: 32'h4100_0000, want: 32'h4040_0000, lat: 30};
    vecs[1]  = '{x: 32'h3F80_0000, want: 32'h0000_0000, lat: 30};
    vecs[2]  = '{x: 32'h3F00_0000, want: 32'hBF80_0000, lat: 30};
    vecs[3]  = '{x: 32'h4000_0000, want: 32'h3F80_0000, lat: 30};
    vecs[4]  = '{x: 32'h3E80_0000, want: 32'hC000_0000, lat: 30};
    vecs[5]  = '{x: 32'h4780_0000, want: 32'h4180_0000, lat: 30};
    vecs[6]  = '{x: 32'h0080_0000, want: 32'hC2FC_0000, lat: 30};
    vecs[7]  = '{x: 32'h7F00_0000, want: 32'h42FE_0000, lat: 30};
    vecs[8]  = '{x: 32'h0000_0000, want: 32'hFF80_0000, lat: 1};
    vecs[9]  = '{x: 32'h0000_0001, want: 32'hFF80_0000, lat: 1};
    vecs[10] = '{x: 32'h8000_0000, want: 32'hFF80_0000, lat: 1};
    vecs[11] = '{x: 32'hC000_0000, want: 32'h7FC0_0000, lat: 1};
    vecs[12] = '{x: 32'h7F80_0000, want: 32'h7F80_0000, lat: 1};
    vecs[13] = '{x: 32'h7FC0_0001, want: 32'h7FC0_0000, lat: 1};
    vecs[14] = '{x: 32'hFF80_0000, want: 32'h7FC0_0000, lat: 1};
    vecs[15] = '{x: 32'h7F80_0001, want: 32'h7FC0_0000, lat: 1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data",  bus.out_data,       32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].x, res, lat);
      chk($sformatf("vec%0d data x=%h", i, vecs[i].x), res, vecs[i].want);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid pulse", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("vec%0d in_ready back", i), 32'(bus.in_ready), 32'd1);
    end

    do_op(32'h4140_0000, res, lat);
    diff = int'(res) - int'(32'h4065_7006);
    checks++;
    if (diff > 2 || diff < -2) begin
      errors++;
      $display("FAIL log2(12.0): got %h want within 2 ulp of 40657006", res);
    end
    @(posedge clk); #1;

    // Backpressure: result must hold while downstream stalls.
    bus.out_ready = 1'b0;
    do_op(32'h4100_0000, res, lat);
    chk("bp latency", 32'(lat), 32'd30);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold cycle %0d {valid,ready,data}", c),
          {bus.out_valid, bus.in_ready, bus.out_data[29:0]},
          {1'b1, 1'b0, 30'h0040_0000});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of ITER discards the operand.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h4140_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset in_ready",  32'(bus.in_ready),  32'd1);
    chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1;
    end
    chk("midreset no stale result", 32'(seen), 32'd0);
    do_op(32'h4100_0000, res, lat);
    chk("post-reset 8.0 data", res, 32'h4040_0000);
    chk("post-reset 8.0 latency", 32'(lat), 32'd30);
    @(posedge clk); #1;

    // Random positive normals against real log2; the absolute term bounds
    // the accumulated squaring truncation for results near zero.
    for (int k = 0; k < 1000; k++) begin
      logic [7:0]  ex;
      logic [22:0] fr;
      logic [31:0] x;
      real         y, g, ay, ulp, tol, err;
      ex = 8'($urandom_range(254, 1));
      fr = 23'($urandom);
      x  = {1'b0, ex, fr};
      do_op(x, res, lat);
      @(posedge clk); #1;
      y   = ref_log2(x);
      g   = fp_to_real(res);
      ay  = (y < 0.0) ? -y : y;
      ulp = (ay == 0.0) ? 0.0 : pow2(int'($floor($ln(ay) / $ln(2.0))) - 23);
      tol = 2.0 * ulp + pow2(-22);
      err = (g > y) ? g - y : y - g;
      checks++;
      if (err > tol) begin
        errors++;
        $display("FAIL rand value x=%h: got %h (%g) want %g within %g", x, res, g, y, tol);
      end
      chk($sformatf("rand sign x=%h", x), 32'(res[31]), 32'(ex < 8'd127));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
